// File: rtl/tm_pkg.sv
// Shared state type and parameter defaults for the Turing-machine host sequencer.
package tm_pkg;

    localparam int TM_DW        = 4;
    localparam int TM_GAP       = 2;
    localparam int TM_HOLD      = 2;
    localparam int TM_SETTLE    = 4;
    localparam int TM_MAX_STEPS = 255;
    localparam int TM_SCW       = 8;
    localparam int TM_TW        = 8;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_HIGH,
        LOAD_GAP,
        DONE_PULSE,
        SETTLE_WAIT,
        RUN_IDLE,
        STEP_HIGH,
        STEP_LOW,
        HALTED,
        TIMEOUT
    } seq_state_t;

endpackage

// File: rtl/tm_host_sequencer_phase_timer.sv
// Loadable down-counter that times the sequencer's Next high/low phases.
module phase_timer #(
    parameter int TW = 8
) (
    input  logic          clock,
    input  logic          Reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic          expire
);

    logic [TW-1:0] count_q;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/tm_host_sequencer.sv
// Host-side Next/Done initiator for the Turing-machine core: load, then run.
// Build option: define AUTO_RUN_EN to free-run steps without step_req.
module tm_host_sequencer
    import tm_pkg::*;
#(
    parameter int DW        = TM_DW,
    parameter int GAP       = TM_GAP,
    parameter int HOLD      = TM_HOLD,
    parameter int SETTLE    = TM_SETTLE,
    parameter int MAX_STEPS = TM_MAX_STEPS,
    parameter int SCW       = TM_SCW
) (
    input  logic           clock,
    input  logic           Reset,
    input  logic [DW-1:0]  word_data,
    input  logic           word_valid,
    input  logic           word_last,
    output logic           word_ready,
    input  logic           step_req,
    input  logic [1:0]     tm_direction,
    output logic [DW-1:0]  tm_input_data,
    output logic           tm_next,
    output logic           tm_done,
    output logic           busy,
    output logic           halted,
    output logic           timeout,
    output logic [SCW-1:0] step_count
);

    localparam int TW = TM_TW;

    seq_state_t    state_q, state_n;
    logic          last_q;
    logic          step_first_q;
    logic          step_inc;
    logic          tmr_load;
    logic          tmr_en;
    logic [TW-1:0] tmr_val;
    logic          tmr_expire;
    logic          unused_dir0;

    assign unused_dir0 = tm_direction[0];

`ifdef AUTO_RUN_EN
    logic unused_step_req;
    assign unused_step_req = step_req;
`endif

    phase_timer #(.TW(TW)) u_timer (
        .clock    (clock),
        .Reset    (Reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_n    = state_q;
        word_ready = 1'b0;
        tmr_en     = 1'b0;
        step_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                word_ready = 1'b1;
                if (word_valid) state_n = LOAD_HIGH;
            end
            LOAD_HIGH: state_n = LOAD_GAP;
            LOAD_GAP: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    if (last_q) begin
                        state_n = DONE_PULSE;
                    end else begin
                        word_ready = 1'b1;
                        if (word_valid) state_n = LOAD_HIGH;
                    end
                end
            end
            DONE_PULSE: state_n = SETTLE_WAIT;
            SETTLE_WAIT: begin
                tmr_en = 1'b1;
                if (tmr_expire) state_n = RUN_IDLE;
            end
            RUN_IDLE: begin
`ifdef AUTO_RUN_EN
                state_n = STEP_HIGH;
`else
                if (step_req) state_n = STEP_HIGH;
`endif
            end
            STEP_HIGH: begin
                tmr_en = 1'b1;
                // halt is judged only on the opening cycle of the step
                if (step_first_q && tm_direction[1]) begin
                    state_n = HALTED;
                end else if (tmr_expire) begin
                    step_inc = 1'b1;
                    state_n  = STEP_LOW;
                end
            end
            STEP_LOW: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    if (step_count == SCW'(MAX_STEPS)) state_n = TIMEOUT;
                    else state_n = RUN_IDLE;
                end
            end
            HALTED, TIMEOUT: state_n = state_q;
            default: state_n = IDLE;
        endcase

        tmr_load = (state_n != state_q);
        tmr_val  = '0;
        unique case (state_n)
            LOAD_GAP:              tmr_val = TW'(GAP - 1);
            STEP_HIGH:             tmr_val = TW'(HOLD - 1);
            STEP_LOW, SETTLE_WAIT: tmr_val = TW'(SETTLE - 1);
            default:               tmr_val = '0;
        endcase
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            tm_next       <= 1'b0;
            tm_done       <= 1'b0;
            tm_input_data <= '0;
            last_q        <= 1'b0;
            step_first_q  <= 1'b0;
            halted        <= 1'b0;
            timeout       <= 1'b0;
            step_count    <= '0;
        end else begin
            state_q      <= state_n;
            tm_next      <= (state_n == LOAD_HIGH) || (state_n == STEP_HIGH);
            tm_done      <= (state_n == DONE_PULSE);
            step_first_q <= (state_n == STEP_HIGH) && (state_q != STEP_HIGH);
            if (word_valid && word_ready) begin
                tm_input_data <= word_data;
                last_q        <= word_last;
            end
            if (state_n == HALTED) halted <= 1'b1;
            if (state_n == TIMEOUT) timeout <= 1'b1;
            if (step_inc && (step_count != SCW'(MAX_STEPS))) begin
                step_count <= step_count + 1'b1;
            end
        end
    end

    assign busy = !((state_q == IDLE) || (state_q == HALTED) ||
                    (state_q == TIMEOUT));

endmodule

// File: doc/tm_host_sequencer.md
Name: tm_host_sequencer

Overview:
- Host-side initiator for the Turing-machine core's Next/Done handshake.
- Load phase: accepts program/tape words from an upstream valid/ready stream and presents each on the core's input_data, one Next pulse per word; then issues Done.
- Run phase: steps the machine with timed Next high/low phases, detects halt on direction[1], counts steps and enforces a step limit.

Parameters:
- DW, 4, word width; matches core input_data.
- GAP, 2, minimum Next-low cycles between load pulses (≥1).
- HOLD, 2, Next-high cycles per run step (≥1).
- SETTLE, 4, Next-low cycles after Done and after each step before the next step may start (≥3).
- MAX_STEPS, 255, step limit; reaching it without halt → TIMEOUT.
- SCW, 8, step counter width; MAX_STEPS < 2**SCW.

Ports:
- clock  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- word_data  in  DW  load word.
- word_valid  in  1  word_data valid.
- word_last  in  1  qualifies the final load word.
- word_ready  out  1  word accepted when word_valid & word_ready.
- step_req  in  1  request one run step (level; sampled in RUN_IDLE).
- tm_direction  in  2  core direction output; bit 1 = halt.
- tm_input_data  out  DW  to core input_data.
- tm_next  out  1  to core Next.
- tm_done  out  1  to core Done.
- busy  out  1  high in all states except IDLE, HALTED, TIMEOUT.
- halted  out  1  sticky halt flag.
- timeout  out  1  sticky step-limit flag.
- step_count  out  SCW  completed steps.

Behaviour:
- Reset (async): state IDLE; all outputs 0; tm_input_data 0; step_count 0; timers 0.
- States: IDLE, LOAD_HIGH, LOAD_GAP, DONE_PULSE, SETTLE_WAIT, RUN_IDLE, STEP_HIGH, STEP_LOW, HALTED, TIMEOUT.
- IDLE: word_ready=1. On handshake, register word_data into tm_input_data and word_last into last_q; go LOAD_HIGH.
- LOAD_HIGH: tm_next=1 for exactly 1 cycle; tm_input_data stable; go LOAD_GAP.
- LOAD_GAP: tm_next=0 for GAP cycles; tm_input_data held.
  - On expiry: last_q → DONE_PULSE.
  - Otherwise word_ready=1 (last gap cycle onward); on handshake go LOAD_HIGH with the new word.
  - word_valid low → remain in LOAD_GAP with ready high; no timeout while waiting.
- DONE_PULSE: tm_done=1 for 1 cycle with tm_next=0; then SETTLE_WAIT.
- SETTLE_WAIT: SETTLE cycles with tm_next=0; then RUN_IDLE.
- RUN_IDLE: step_req=1 → STEP_HIGH.
- STEP_HIGH: tm_next=1 for HOLD cycles.
  - tm_direction[1] sampled on the first STEP_HIGH cycle. If 1: set halted, drop tm_next next cycle, go HALTED; step_count not incremented.
  - Else on expiry: step_count += 1, go STEP_LOW.
- STEP_LOW: tm_next=0 for SETTLE cycles.
  - If step_count == MAX_STEPS: set timeout, go TIMEOUT.
  - Else go RUN_IDLE.
- HALTED, TIMEOUT: terminal; tm_next=tm_done=0; exit only via Reset.
- tm_next and tm_done are never high together; both are registered outputs (no combinational path from inputs).
- word_valid during run phase is ignored (word_ready=0). step_req during load is ignored.
- Reset mid-operation: immediate return to IDLE; tm_next drops asynchronously. The core shares Reset, so both restart together.
- step_count saturates at MAX_STEPS; never wraps.

Optional Feature:
- Macro AUTO_RUN_EN.
- Defined: RUN_IDLE advances to STEP_HIGH automatically after 1 cycle; step_req is ignored, and the machine free-runs until HALTED/TIMEOUT.
- Undefined: stepping only on step_req, as above.

Decomposition:
- Package tm_pkg: state enum type seq_state_t; localparam defaults for DW, GAP, HOLD, SETTLE.
- Sub-module phase_timer: loadable down-counter with load value, en and expire flag; shared by LOAD_GAP, STEP_HIGH, STEP_LOW and SETTLE_WAIT.

Test Plan:
- Load 3 words 4'h1, 4'h2, 4'hA (last on third), valid always high → exactly 3 one-cycle tm_next pulses, each with matching tm_input_data, ≥2 low cycles apart, then one tm_done pulse; ready low after third accept.
- Upstream stall: drop word_valid for 10 cycles after word 1 → tm_next stays 0, word_ready stays 1, no tm_done; load resumes cleanly.
- Run 5 steps with tm_direction=2'b01, step_req held high → 5 Next-high windows of 2 cycles; step_count=5; halted=0.
- Set tm_direction=2'b10 before step 6 → a single Next-high cycle, then halted=1, state HALTED, step_count stays 5, busy=0.
- MAX_STEPS=3, no halt → timeout=1 after 3rd step; step_count=3; no further tm_next.
- Assert Reset during STEP_HIGH → tm_next=0 immediately; all flags clear; IDLE with word_ready=1 on next cycle after release.
